// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus rx/tx byte handshakes and status flags of the SPI target
interface spi_slave_if #(parameter int DATA_W = 8);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_overrun;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_underrun;
  logic              busy;
  logic              frame_abort;
  modport slave (
    input  sclk, cs_n, mosi, rx_ready, tx_data, tx_valid,
    output miso, miso_oe, rx_data, rx_valid, rx_overrun, tx_ready, tx_underrun, busy, frame_abort
  );
  modport master (
    output sclk, cs_n, mosi, rx_ready, tx_data, tx_valid,
    input  miso, miso_oe, rx_data, rx_valid, rx_overrun, tx_ready, tx_underrun, busy, frame_abort
  );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI mode-0 target with 1-entry tx buffer and rx holding register
module spi_slave #(
  parameter int                DATA_W       = 8,
  parameter int                SYNC_STAGES  = 2,
  parameter logic [DATA_W-1:0] TX_IDLE_BYTE = {DATA_W{1'b1}}
) (
  input logic       clk,
  input logic       rst_n,
  spi_slave_if.slave bus
);
  localparam int CW = $clog2(DATA_W) + 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, mosi_sr;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic                   start, stop, rise, fall, load, shift, wr, last;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_W-1:0]      rx_shift, rx_nx, tx_shift, buf_data, rx_data;
  logic                   buf_full, rx_valid, rx_overrun, tx_underrun, frame_abort;
  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign cs_s      = cs_sr[SYNC_STAGES-1];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign wr        = bus.tx_valid & ~buf_full;
  assign rx_nx     = {rx_shift[DATA_W-2:0], mosi_s};
  assign last      = bit_cnt == CW'(DATA_W - 1);
  assign bus.miso        = tx_shift[DATA_W-1];
  assign bus.miso_oe     = state == ACTIVE;
  assign bus.busy        = state == ACTIVE;
  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.rx_overrun  = rx_overrun;
  assign bus.tx_ready    = ~buf_full;
  assign bus.tx_underrun = tx_underrun;
  assign bus.frame_abort = frame_abort;
  // synchronise SPI pins; cs resets low so a cs_n held low through reset never looks like a fresh select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sr <= '0;
      cs_sr   <= '0;
      mosi_sr <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], bus.sclk};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], bus.mosi};
      sclk_d  <= sclk_s;
      cs_d    <= cs_s;
    end
  end
  // frame control: cs_n edges gate sclk edges, a cs_n rise masks any coincident sclk edge
  always_comb begin
    start    = (state == IDLE) && cs_fall;
    stop     = (state == ACTIVE) && cs_rise;
    rise     = (state == ACTIVE) && !cs_rise && sclk_rise;
    fall     = (state == ACTIVE) && !cs_rise && sclk_fall;
    load     = start || (fall && bit_cnt == '0);
    shift    = fall && bit_cnt != '0;
    state_nx = start ? ACTIVE : stop ? IDLE : state;
  end
  // state register, tx buffer, shift registers and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      buf_data    <= '0;
      buf_full    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_nx;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      if (rx_valid && bus.rx_ready) rx_valid <= 1'b0;
      if (wr) begin
        buf_full <= 1'b1;
        buf_data <= bus.tx_data;
      end else if (load) buf_full <= 1'b0;
      if (load) begin
        tx_shift    <= buf_full ? buf_data : TX_IDLE_BYTE;
        tx_underrun <= ~buf_full;
      end else if (shift) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      if (start) bit_cnt <= '0;
      if (stop) begin
        tx_shift    <= '0;
        rx_shift    <= '0;
        bit_cnt     <= '0;
        frame_abort <= bit_cnt != '0;
      end
      if (rise) begin
        rx_shift <= rx_nx;
        if (last) begin
          rx_data    <= rx_nx;
          rx_valid   <= 1'b1;
          rx_overrun <= rx_valid && !bus.rx_ready;
          bit_cnt    <= '0;
        end else bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master stimulus against spi_slave with hand-computed expectations
module tb_spi_slave;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0, bad = 0, hp = 8;
  int rx_n = 0, n_ovr = 0, n_und = 0, n_abt = 0;
  logic [DW-1:0] rx_log [0:1023];
  spi_slave_if #(.DATA_W(DW)) bus ();
  spi_slave #(.DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  // free-running clock
  always #5 clk = ~clk;
  // log consumed rx bytes and count status pulses at the DUT's own sampling edge
  always @(posedge clk) begin
    if (bus.rx_valid && bus.rx_ready) begin
      rx_log[rx_n[9:0]] <= bus.rx_data;
      rx_n <= rx_n + 1;
    end
    if (bus.rx_overrun) n_ovr <= n_ovr + 1;
    if (bus.tx_underrun) n_und <= n_und + 1;
    if (bus.frame_abort) n_abt <= n_abt + 1;
  end
  // global time bound
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_tx(input logic [DW-1:0] b);
    int n = 0;
    while (!bus.tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("tx_ready_wait", 32'(bus.tx_ready), 1);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask
  task automatic cs_low;
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (hp) @(negedge clk);
  endtask
  task automatic cs_high;
    repeat (hp) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (hp + 4) @(negedge clk);
  endtask
  task automatic spi_xfer(input logic [DW-1:0] mo, input int nb, output logic [DW-1:0] mi);
    mi = '0;
    for (int i = DW - 1; i >= DW - nb; i--) begin
      bus.mosi = mo[i];
      repeat (hp) @(negedge clk);
      mi[i] = bus.miso;
      bus.sclk = 1'b1;
      repeat (hp) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask
  initial begin
    logic [DW-1:0] mi, m0, m1, m2;
    logic [DW-1:0] mo_v [64];
    logic [DW-1:0] tx_v [64];
    logic [DW-1:0] mi_v [64];
    int base, ob, ub, ab;
    rst_n = 1'b0;
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.rx_ready = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(bus.miso), 0);
    chk("rst_miso_oe", 32'(bus.miso_oe), 0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 0);
    chk("rst_rx_data", 32'(bus.rx_data), 0);
    chk("rst_tx_ready", 32'(bus.tx_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    // single byte: tx A5, master sends 3C, rx held until consumed
    bus.rx_ready = 1'b0;
    base = rx_n;
    send_tx(8'hA5);
    chk("t1_tx_full", 32'(bus.tx_ready), 0);
    cs_low;
    chk("t1_busy", 32'(bus.busy), 1);
    chk("t1_miso_oe", 32'(bus.miso_oe), 1);
    chk("t1_miso_msb", 32'(bus.miso), 1);
    chk("t1_tx_freed", 32'(bus.tx_ready), 1);
    spi_xfer(8'h3C, 8, mi);
    cs_high;
    chk("t1_miso", 32'(mi), 32'hA5);
    chk("t1_rx_valid", 32'(bus.rx_valid), 1);
    chk("t1_rx_data", 32'(bus.rx_data), 32'h3C);
    chk("t1_idle_busy", 32'(bus.busy), 0);
    chk("t1_idle_oe", 32'(bus.miso_oe), 0);
    bus.rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_rx_clr", 32'(bus.rx_valid), 0);
    chk("t1_rx_cnt", 32'(rx_n - base), 1);
    chk("t1_rx_log", 32'(rx_log[base]), 32'h3C);
    // three back-to-back bytes, third load underruns
    base = rx_n;
    send_tx(8'hC3);
    cs_low;
    send_tx(8'h5A);
    ub = n_und;
    spi_xfer(8'h01, 8, m0);
    spi_xfer(8'h02, 8, m1);
    fork
      spi_xfer(8'h03, 8, m2);
      begin
        repeat (20) @(negedge clk);
        send_tx(8'h99);
      end
    join
    cs_high;
    chk("t2_miso0", 32'(m0), 32'hC3);
    chk("t2_miso1", 32'(m1), 32'h5A);
    chk("t2_miso2", 32'(m2), 32'hFF);
    chk("t2_underrun", 32'(n_und - ub), 1);
    chk("t2_rx_cnt", 32'(rx_n - base), 3);
    chk("t2_rx0", 32'(rx_log[base]), 32'h01);
    chk("t2_rx1", 32'(rx_log[base+1]), 32'h02);
    chk("t2_rx2", 32'(rx_log[base+2]), 32'h03);
    // overrun: two bytes with consumer stalled
    base = rx_n;
    ob = n_ovr;
    bus.rx_ready = 1'b0;
    cs_low;
    spi_xfer(8'h11, 8, mi);
    spi_xfer(8'h22, 8, mi);
    cs_high;
    chk("t3_rx_data", 32'(bus.rx_data), 32'h22);
    chk("t3_rx_valid", 32'(bus.rx_valid), 1);
    chk("t3_overrun", 32'(n_ovr - ob), 1);
    bus.rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t3_rx_cnt", 32'(rx_n - base), 1);
    chk("t3_rx_log", 32'(rx_log[base]), 32'h22);
    // aborted frame after 5 bits, then a clean frame
    base = rx_n;
    ab = n_abt;
    cs_low;
    spi_xfer(8'hFF, 5, mi);
    cs_high;
    chk("t4_abort", 32'(n_abt - ab), 1);
    chk("t4_no_rx", 32'(rx_n - base), 0);
    chk("t4_oe", 32'(bus.miso_oe), 0);
    chk("t4_busy", 32'(bus.busy), 0);
    chk("t4_miso", 32'(bus.miso), 0);
    cs_low;
    spi_xfer(8'h7E, 8, mi);
    cs_high;
    chk("t4_rx_cnt", 32'(rx_n - base), 1);
    chk("t4_rx_log", 32'(rx_log[base]), 32'h7E);
    chk("t4_abort_once", 32'(n_abt - ab), 1);
    // asynchronous reset mid-byte, then a clean frame
    send_tx(8'hAA);
    cs_low;
    send_tx(8'h55);
    chk("t5_tx_full", 32'(bus.tx_ready), 0);
    spi_xfer(8'h00, 2, mi);
    repeat (hp) @(negedge clk);
    chk("t5_miso_pre", 32'(bus.miso), 1);
    chk("t5_busy_pre", 32'(bus.busy), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_miso", 32'(bus.miso), 0);
    chk("t5_oe", 32'(bus.miso_oe), 0);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_tx_ready", 32'(bus.tx_ready), 1);
    chk("t5_rx_valid", 32'(bus.rx_valid), 0);
    chk("t5_rx_data", 32'(bus.rx_data), 0);
    @(negedge clk);
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    base = rx_n;
    send_tx(8'h0F);
    cs_low;
    spi_xfer(8'hF0, 8, mi);
    cs_high;
    chk("t5_miso_frame", 32'(mi), 32'h0F);
    chk("t5_rx_cnt", 32'(rx_n - base), 1);
    chk("t5_rx_log", 32'(rx_log[base]), 32'hF0);
    // loopback stream of random bytes at half-period 25
    hp = 25;
    base = rx_n;
    ob = n_ovr;
    for (int k = 0; k < 64; k++) begin
      mo_v[k] = DW'($urandom_range(255));
      tx_v[k] = DW'($urandom_range(255));
    end
    send_tx(tx_v[0]);
    cs_low;
    fork
      for (int k = 1; k < 64; k++) send_tx(tx_v[k]);
      for (int k = 0; k < 64; k++) begin
        spi_xfer(mo_v[k], 8, mi);
        mi_v[k] = mi;
      end
    join
    cs_high;
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("t6_miso%0d", k), 32'(mi_v[k]), 32'(tx_v[k]));
      chk($sformatf("t6_rx%0d", k), 32'(rx_log[base+k]), 32'(mo_v[k]));
    end
    chk("t6_rx_cnt", 32'(rx_n - base), 64);
    chk("t6_overrun", 32'(n_ovr - ob), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
